// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch, register-file, EX-feedback and ID/EX buses of the decode stage
interface id_stage_if;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;
  logic        stall;
  logic        flush;
  logic [4:0]  gpr_rd_addr_0;
  logic [4:0]  gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0;
  logic [31:0] gpr_rd_data_1;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic        ex_mem_rd;
  logic [31:0] ex_fwd_data;
  logic [31:0] id_pc;
  logic        id_en;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0;
  logic [31:0] id_alu_in_1;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic        id_mem_rd;
  logic        id_mem_wr;
  logic [31:0] id_mem_wr_data;
  logic        id_exp;
  logic        ld_hazard;

  modport master (
    output if_pc, if_insn, if_en, stall, flush,
    output gpr_rd_data_0, gpr_rd_data_1,
    output ex_dst_addr, ex_gpr_we_, ex_mem_rd, ex_fwd_data,
    input  gpr_rd_addr_0, gpr_rd_addr_1,
    input  id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_dst_addr,
    input  id_gpr_we_, id_mem_rd, id_mem_wr, id_mem_wr_data, id_exp, ld_hazard
  );

  modport slave (
    input  if_pc, if_insn, if_en, stall, flush,
    input  gpr_rd_data_0, gpr_rd_data_1,
    input  ex_dst_addr, ex_gpr_we_, ex_mem_rd, ex_fwd_data,
    output gpr_rd_addr_0, gpr_rd_addr_1,
    output id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_dst_addr,
    output id_gpr_we_, id_mem_rd, id_mem_wr, id_mem_wr_data, id_exp, ld_hazard
  );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode with EX forwarding, load-use detection and ID/EX register
module id_stage (
  input logic      clk,
  input logic      reset,
  id_stage_if.slave bus
);
  logic [5:0]  w_op;
  logic [4:0]  w_ra, w_rb, w_rc;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic        w_is_r, w_is_addi, w_is_ldw, w_is_stw, w_is_nop, w_illegal;
  logic        w_use_ra, w_use_rb, w_writes, w_imm_sel;
  logic        w_ex_alu_wr, w_ex_ld;
  logic [31:0] w_opa, w_opb;
  logic [3:0]  w_alu_op;
  logic [4:0]  w_dst;
  logic        w_hazard;

  logic [31:0] r_pc, r_in_0, r_in_1, r_wr_data;
  logic [3:0]  r_alu_op;
  logic [4:0]  r_dst;
  logic        r_en, r_gpr_we_, r_mem_rd, r_mem_wr, r_exp;

  assign w_op  = bus.if_insn[31:26];
  assign w_ra  = bus.if_insn[25:21];
  assign w_rb  = bus.if_insn[20:16];
  assign w_rc  = bus.if_insn[15:11];
  assign w_imm = bus.if_insn[15:0];
  assign w_sext = {{16{w_imm[15]}}, w_imm};

  assign w_is_r    = (w_op <= 6'h03);
  assign w_is_addi = (w_op == 6'h04);
  assign w_is_ldw  = (w_op == 6'h05);
  assign w_is_stw  = (w_op == 6'h06);
  assign w_is_nop  = (w_op == 6'h3F);
  assign w_illegal = (w_op > 6'h06) && !w_is_nop;
  assign w_use_ra  = (w_op <= 6'h06);
  assign w_use_rb  = w_is_r || w_is_stw;
  assign w_writes  = w_is_r || w_is_addi || w_is_ldw;
  assign w_imm_sel = w_is_addi || w_is_ldw || w_is_stw;

  assign bus.gpr_rd_addr_0 = w_ra;
  assign bus.gpr_rd_addr_1 = w_rb;

  // A load in EX has no data yet, so only ALU results are forwarded from EX.
  assign w_ex_alu_wr = !bus.ex_gpr_we_ && !bus.ex_mem_rd;
  assign w_ex_ld     = !bus.ex_gpr_we_ && bus.ex_mem_rd;

  assign w_opa = (w_ex_alu_wr && (w_ra == bus.ex_dst_addr)) ? bus.ex_fwd_data : bus.gpr_rd_data_0;
  assign w_opb = (w_ex_alu_wr && (w_rb == bus.ex_dst_addr)) ? bus.ex_fwd_data : bus.gpr_rd_data_1;

  assign w_hazard = bus.if_en && w_ex_ld &&
                    ((w_use_ra && (w_ra == bus.ex_dst_addr)) ||
                     (w_use_rb && (w_rb == bus.ex_dst_addr)));
  assign bus.ld_hazard = w_hazard;

  assign w_alu_op = w_is_r ? {2'b00, w_op[1:0]} : 4'h0;
  assign w_dst    = w_is_r ? w_rc : ((w_is_addi || w_is_ldw) ? w_rb : 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= 32'd0;
      r_en      <= 1'b0;
      r_alu_op  <= 4'd0;
      r_in_0    <= 32'd0;
      r_in_1    <= 32'd0;
      r_dst     <= 5'd0;
      r_gpr_we_ <= 1'b1;
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_wr_data <= 32'd0;
      r_exp     <= 1'b0;
    end else if (bus.flush || (!bus.stall && w_hazard)) begin
      // Bubble: kill the control fields, leave the data fields as they were.
      r_en      <= 1'b0;
      r_gpr_we_ <= 1'b1;
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_exp     <= 1'b0;
    end else if (!bus.stall) begin
      r_pc      <= bus.if_pc;
      r_en      <= bus.if_en;
      r_alu_op  <= w_alu_op;
      r_in_0    <= w_opa;
      r_in_1    <= w_imm_sel ? w_sext : w_opb;
      r_dst     <= w_dst;
      r_gpr_we_ <= !(bus.if_en && w_writes);
      r_mem_rd  <= bus.if_en && w_is_ldw;
      r_mem_wr  <= bus.if_en && w_is_stw;
      r_wr_data <= w_opb;
      r_exp     <= bus.if_en && w_illegal;
    end
  end

  assign bus.id_pc          = r_pc;
  assign bus.id_en          = r_en;
  assign bus.id_alu_op      = r_alu_op;
  assign bus.id_alu_in_0    = r_in_0;
  assign bus.id_alu_in_1    = r_in_1;
  assign bus.id_dst_addr    = r_dst;
  assign bus.id_gpr_we_     = r_gpr_we_;
  assign bus.id_mem_rd      = r_mem_rd;
  assign bus.id_mem_wr      = r_mem_wr;
  assign bus.id_mem_wr_data = r_wr_data;
  assign bus.id_exp         = r_exp;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;
  logic clk = 1'b0;
  logic reset;
  id_stage_if bus ();

  id_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        full;
    logic        en;
    logic [3:0]  op;
    logic [31:0] in0, in1, wd, pc;
    logic [4:0]  dst;
    logic        we_, mrd, mwr, ex;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] g);
    if (bus.ex_gpr_we_ == 1'b0 && bus.ex_mem_rd == 1'b0 && a == bus.ex_dst_addr) return bus.ex_fwd_data;
    return g;
  endfunction

  function automatic logic model_hazard();
    logic [5:0] op;
    logic [4:0] ra, rb;
    logic ura, urb;
    op  = bus.if_insn[31:26];
    ra  = bus.if_insn[25:21];
    rb  = bus.if_insn[20:16];
    ura = (op < 6'd7);
    urb = (op < 6'd4) || (op == 6'd6);
    return bus.if_en && bus.ex_mem_rd && !bus.ex_gpr_we_ &&
           ((ura && ra == bus.ex_dst_addr) || (urb && rb == bus.ex_dst_addr));
  endfunction

  function automatic exp_t model_load();
    exp_t e;
    logic [31:0] a, b, sx;
    logic wr, ill, ld, st;
    logic [15:0] imm;
    imm = bus.if_insn[15:0];
    a  = fwd(bus.if_insn[25:21], bus.gpr_rd_data_0);
    b  = fwd(bus.if_insn[20:16], bus.gpr_rd_data_1);
    sx = {{16{imm[15]}}, imm};
    e.full = bus.if_en; e.en = bus.if_en; e.pc = bus.if_pc;
    e.op = 4'd0; e.in0 = a; e.in1 = b; e.wd = b; e.dst = 5'd0;
    wr = 0; ill = 0; ld = 0; st = 0;
    case (bus.if_insn[31:26])
      6'h00: begin e.op = 4'd0; e.dst = bus.if_insn[15:11]; wr = 1; end
      6'h01: begin e.op = 4'd1; e.dst = bus.if_insn[15:11]; wr = 1; end
      6'h02: begin e.op = 4'd2; e.dst = bus.if_insn[15:11]; wr = 1; end
      6'h03: begin e.op = 4'd3; e.dst = bus.if_insn[15:11]; wr = 1; end
      6'h04: begin e.in1 = sx; e.dst = bus.if_insn[20:16]; wr = 1; end
      6'h05: begin e.in1 = sx; e.dst = bus.if_insn[20:16]; wr = 1; ld = 1; end
      6'h06: begin e.in1 = sx; st = 1; end
      6'h3F: ;
      default: ill = 1;
    endcase
    e.we_ = !(bus.if_en && wr);
    e.mrd = bus.if_en && ld;
    e.mwr = bus.if_en && st;
    e.ex  = bus.if_en && ill;
    return e;
  endfunction

  function automatic exp_t bubble(input exp_t p);
    exp_t e;
    e = p; e.full = 0; e.en = 0; e.we_ = 1; e.mrd = 0; e.mwr = 0; e.ex = 0;
    return e;
  endfunction

  task automatic cycle(input string tag);
    exp_t e, o;
    logic hz;
    #1;
    hz = model_hazard();
    check_val({tag, "_ldhz"}, bus.ld_hazard, hz);
    check_val({tag, "_rda0"}, bus.gpr_rd_addr_0, bus.if_insn[25:21]);
    check_val({tag, "_rda1"}, bus.gpr_rd_addr_1, bus.if_insn[20:16]);
    if (reset) begin
      e.full = 1; e.en = 0; e.op = 0; e.in0 = 0; e.in1 = 0; e.wd = 0; e.pc = 0;
      e.dst = 0; e.we_ = 1; e.mrd = 0; e.mwr = 0; e.ex = 0;
    end else if (bus.flush) e = bubble(last);
    else if (bus.stall) e = last;
    else if (hz) e = bubble(last);
    else e = model_load();
    q.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    o = q.pop_front();
    check_val({tag, "_en"},  bus.id_en,      o.en);
    check_val({tag, "_we"},  bus.id_gpr_we_, o.we_);
    check_val({tag, "_mrd"}, bus.id_mem_rd,  o.mrd);
    check_val({tag, "_mwr"}, bus.id_mem_wr,  o.mwr);
    check_val({tag, "_exp"}, bus.id_exp,     o.ex);
    if (o.full) begin
      check_val({tag, "_pc"},  bus.id_pc,          o.pc);
      check_val({tag, "_op"},  bus.id_alu_op,      o.op);
      check_val({tag, "_in0"}, bus.id_alu_in_0,    o.in0);
      check_val({tag, "_in1"}, bus.id_alu_in_1,    o.in1);
      check_val({tag, "_dst"}, bus.id_dst_addr,    o.dst);
      check_val({tag, "_wd"},  bus.id_mem_wr_data, o.wd);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] insn, input logic en,
                       input logic [31:0] g0, input logic [31:0] g1);
    bus.if_pc = pc; bus.if_insn = insn; bus.if_en = en;
    bus.gpr_rd_data_0 = g0; bus.gpr_rd_data_1 = g1;
  endtask

  task automatic set_ex(input logic [4:0] d, input logic we_, input logic rd, input logic [31:0] f);
    bus.ex_dst_addr = d; bus.ex_gpr_we_ = we_; bus.ex_mem_rd = rd; bus.ex_fwd_data = f;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [15:0] low);
    return {op, ra, rb, low};
  endfunction

  initial begin
    reset = 1; bus.stall = 0; bus.flush = 0;
    fetch(32'h0, mk(6'h00, 5'd7, 5'd9, 16'h0), 1'b1, 32'h1, 32'h2);
    set_ex(5'd0, 1'b1, 1'b0, 32'h0);
    cycle("reset");
    reset = 0;

    fetch(32'h100, 32'h00221800, 1'b1, 32'd5, 32'd7);
    cycle("add");
    fetch(32'h104, mk(6'h04, 5'd1, 5'd4, 16'hFFFF), 1'b1, 32'd10, 32'd3);
    cycle("addi");
    set_ex(5'd1, 1'b0, 1'b0, 32'h55);
    fetch(32'h108, mk(6'h01, 5'd1, 5'd2, {5'd5, 11'd0}), 1'b1, 32'd9, 32'd4);
    cycle("sub_fwd");
    fetch(32'h10C, mk(6'h06, 5'd3, 5'd1, 16'h8004), 1'b1, 32'h20, 32'h77);
    cycle("stw_fwd");

    set_ex(5'd2, 1'b0, 1'b1, 32'hDEAD);
    fetch(32'h110, mk(6'h00, 5'd4, 5'd2, {5'd6, 11'd0}), 1'b1, 32'd11, 32'd12);
    cycle("lduse");
    set_ex(5'd0, 1'b1, 1'b0, 32'h0);
    fetch(32'h110, mk(6'h00, 5'd4, 5'd2, {5'd6, 11'd0}), 1'b1, 32'd11, 32'd99);
    cycle("lduse_re");
    set_ex(5'd2, 1'b0, 1'b1, 32'h0);
    fetch(32'h114, mk(6'h05, 5'd3, 5'd2, 16'h0010), 1'b1, 32'h40, 32'h1);
    cycle("ldw_nohz");

    fetch(32'h118, mk(6'h03, 5'd8, 5'd9, {5'd10, 11'd0}), 1'b1, 32'hF0, 32'h0F);
    set_ex(5'd0, 1'b1, 1'b0, 32'h0);
    cycle("or");
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      fetch(32'h200 + 4 * i, $urandom, 1'b1, $urandom, $urandom);
      cycle("stall");
    end
    bus.flush = 1;
    cycle("flush_stall");
    bus.flush = 0; bus.stall = 0;

    fetch(32'h11C, mk(6'h10, 5'd1, 5'd2, 16'h0), 1'b1, 32'h1, 32'h2);
    cycle("illegal");
    fetch(32'h120, mk(6'h3F, 5'd0, 5'd0, 16'h0), 1'b1, 32'h1, 32'h2);
    cycle("nop");
    fetch(32'h124, mk(6'h02, 5'd1, 5'd2, {5'd3, 11'd0}), 1'b0, 32'h1, 32'h2);
    cycle("if_en0");

    fetch(32'h128, mk(6'h00, 5'd1, 5'd2, {5'd3, 11'd0}), 1'b1, 32'h33, 32'h44);
    cycle("pre_rst");
    bus.stall = 1;
    cycle("stall_valid");
    reset = 1;
    cycle("rst_stall");
    reset = 0; bus.stall = 0;

    for (int i = 0; i < 60; i++) begin
      logic [5:0] ops[9];
      ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h3F, 6'h2A};
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      set_ex($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      fetch($urandom, mk(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom), ($urandom_range(0, 7) != 0), $urandom, $urandom);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter none; encoding fixed: insn[31:26] opcode, [25:21] ra, [20:16] rb, [15:11] rc, [15:0] imm.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled only on rising clk.
REQ-004 if_pc  input  32  PC of fetched instruction.
REQ-005 if_insn  input  32  fetched instruction word.
REQ-006 if_en  input  1  fetched instruction valid.
REQ-007 stall  input  1  hold ID/EX register.
REQ-008 flush  input  1  discard ID contents (branch/exception).
REQ-009 gpr_rd_addr_0 / gpr_rd_addr_1  output  5 each  register-file read addresses (ra, rb).
REQ-010 gpr_rd_data_0 / gpr_rd_data_1  input  32 each  register-file read data (WB bypass already applied there).
REQ-011 ex_dst_addr  input  5  destination of instruction in EX.
REQ-012 ex_gpr_we_  input  1  EX writes GPR, active-low.
REQ-013 ex_mem_rd  input  1  EX instruction is a load.
REQ-014 ex_fwd_data  input  32  EX ALU result for forwarding.
REQ-015 id_pc  output  32; id_en  output  1; id_alu_op  output  4; id_alu_in_0 / id_alu_in_1  output  32 each; id_dst_addr  output  5; id_gpr_we_  output  1 (active-low); id_mem_rd  output  1; id_mem_wr  output  1; id_mem_wr_data  output  32; id_exp  output  1 (illegal opcode).
REQ-016 ld_hazard  output  1  combinational; tells IF to hold PC/instruction.

Function
REQ-017 Opcodes SHALL decode: 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR (rc <= ra op rb); 0x04 ADDI (rb <= ra + sext(imm)); 0x05 LDW (rb <= mem[ra+sext(imm)]); 0x06 STW (mem[ra+sext(imm)] <= rb); 0x3F NOP; all others illegal.
REQ-018 id_alu_op SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR; ADDI/LDW/STW use ADD; NOP/illegal use 0.
REQ-019 gpr_rd_addr_0 SHALL equal if_insn[25:21], gpr_rd_addr_1 SHALL equal if_insn[20:16], combinationally, regardless of if_en.
REQ-020 Source used: ra for opcodes 0x00-0x06; rb for 0x00-0x03 and 0x06.
REQ-021 Forwarding: operand SHALL be ex_fwd_data when used source addr == ex_dst_addr, ex_gpr_we_=0, ex_mem_rd=0; else gpr data; r0 not special.
REQ-022 id_alu_in_1 SHALL be sext(imm) (bit 15 replicated) for ADDI/LDW/STW, forwarded rb otherwise; id_mem_wr_data SHALL be forwarded rb.
REQ-023 ld_hazard SHALL be 1 iff if_en=1, ex_mem_rd=1, ex_gpr_we_=0, and ex_dst_addr equals a used source of if_insn.
REQ-024 ID/EX register update priority per cycle: reset > flush > stall > ld_hazard > normal load.
REQ-025 flush (not reset): id_en=0, id_gpr_we_=1, id_mem_rd=0, id_mem_wr=0, id_exp=0; other fields don't-care but held.
REQ-026 stall (no flush): all ID/EX outputs hold previous values; ld_hazard still reported.
REQ-027 ld_hazard (no stall/flush): bubble inserted as REQ-025; next cycle re-decodes held instruction with load result from gpr bypass.
REQ-028 Normal load: id_en=if_en; if if_en=0 outputs are a bubble per REQ-025; id_pc=if_pc; latency from if_insn to id_* outputs exactly 1 cycle.
REQ-029 id_gpr_we_=0 for ADD/SUB/AND/OR/ADDI/LDW; 1 for STW/NOP/illegal; id_dst_addr=rc for R-type, rb for ADDI/LDW, 0 otherwise.
REQ-030 Illegal opcode with if_en=1: id_exp=1, id_en=1, id_gpr_we_=1, no memory access.

Reset
REQ-031 On reset=1 at clk edge all outputs registered SHALL become 0 except id_gpr_we_=1; reset mid-stall or mid-hazard overrides both.
REQ-032 Combinational outputs (gpr_rd_addr_*, ld_hazard) SHALL follow inputs during reset.

Verification
REQ-033 ADD r3=r1+r2 (insn 0x00221800), gpr data 5 and 7, no EX match -> next cycle id_alu_op=0, in_0=5, in_1=7, id_dst_addr=3, id_gpr_we_=0, id_en=1.
REQ-034 ADDI imm=0xFFFF, ra data 10 -> id_alu_in_1=0xFFFFFFFF, id_dst_addr=rb.
REQ-035 EX ADD to r1 (ex_gpr_we_=0, ex_mem_rd=0, ex_fwd_data=0x55), ID SUB using r1 -> id_alu_in_0=0x55, ld_hazard=0.
REQ-036 EX LDW to r2, ID ADD using r2 -> ld_hazard=1, next cycle bubble (id_en=0, id_gpr_we_=1); following cycle with EX cleared -> ADD issued normally.
REQ-037 stall=1 for 3 cycles with changing if_insn -> outputs constant; flush=1 with stall=1 -> bubble; opcode 0x10 -> id_exp=1, id_gpr_we_=1.
REQ-038 reset=1 asserted during stall with valid ID contents -> next edge all outputs 0, id_gpr_we_=1.
